// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A, fixed priority) vs. multi-cycle
// writeback (B, valid/ready), with a pending-write scoreboard and B starvation protection.
module rf_wport_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_we,
   input  logic [4:0]  a_rd,
   input  logic [31:0] a_wd,
   input  logic        b_valid,
   input  logic [4:0]  b_rd,
   input  logic [31:0] b_wd,
   output logic        b_ready,
   output logic        a_freeze,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   output logic        iss_ready,
   input  logic [4:0]  chk_r1,
   input  logic [4:0]  chk_r2,
   output logic        busy1,
   output logic        busy2,
   output logic        rf_we,
   output logic [4:0]  rf_wr,
   output logic [31:0] rf_wd,
   output logic        err
);

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [31:0]      pending, pending_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
   logic             freeze_nxt, err_nxt;
   logic             b_commit, b_refused, iss_take;

   always_comb begin
      rf_we   = 1'b0;
      rf_wr   = '0;
      rf_wd   = '0;
      b_ready = 1'b0;
      if (rst_n) begin
         if (a_we) begin
            rf_we = 1'b1;
            rf_wr = a_rd;
            rf_wd = a_wd;
         end else if (b_valid) begin
            rf_we   = 1'b1;
            rf_wr   = b_rd;
            rf_wd   = b_wd;
            b_ready = 1'b1;
         end
      end
   end

   assign b_commit  = b_ready;
   assign b_refused = b_valid & a_we;

   // pending[0] is never set, so x0 reads as not busy and x0 issues are always accepted
   assign iss_ready = rst_n & iss_valid & ~pending[iss_rd];
   assign iss_take  = iss_ready & (iss_rd != 5'd0);
   assign busy1     = pending[chk_r1];
   assign busy2     = pending[chk_r2];

   always_comb begin
      pending_nxt = pending;
      if (b_commit) pending_nxt[b_rd] = 1'b0;
      if (iss_take) pending_nxt[iss_rd] = 1'b1;
      pending_nxt[0] = 1'b0;

      starve_cnt_nxt = '0;
      if (b_refused)
         starve_cnt_nxt = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;

      freeze_nxt = a_freeze;
      if (b_commit)
         freeze_nxt = 1'b0;
      else if (b_refused && (starve_cnt == LIMIT_M1))
         freeze_nxt = 1'b1;

      // protocol violations: A while frozen, WAW on a pending reg, B commit to a non-pending reg
      err_nxt = err
              | (a_we & a_freeze)
              | (a_we & pending[a_rd])
              | (b_commit & (b_rd != 5'd0) & ~pending[b_rd]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= '0;
         starve_cnt <= '0;
         a_freeze   <= 1'b0;
         err        <= 1'b0;
      end else begin
         pending    <= pending_nxt;
         starve_cnt <= starve_cnt_nxt;
         a_freeze   <= freeze_nxt;
         err        <= err_nxt;
      end
   end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration and scoreboard rules.
module tb_rf_wport_arbiter;
   localparam int SL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_we, b_valid, iss_valid;
   logic [4:0]  a_rd, b_rd, iss_rd, chk_r1, chk_r2;
   logic [31:0] a_wd, b_wd;
   logic        b_ready, a_freeze, iss_ready, busy1, busy2, rf_we, err;
   logic [4:0]  rf_wr;
   logic [31:0] rf_wd;

   int nvec = 0;
   int nerr = 0;

   rf_wport_arbiter #(.STARVE_LIMIT(SL), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_we(a_we), .a_rd(a_rd), .a_wd(a_wd),
      .b_valid(b_valid), .b_rd(b_rd), .b_wd(b_wd), .b_ready(b_ready),
      .a_freeze(a_freeze),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .chk_r1(chk_r1), .chk_r2(chk_r2), .busy1(busy1), .busy2(busy2),
      .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd), .err(err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      a_we = 0; a_rd = 0; a_wd = 0;
      b_valid = 0; b_rd = 0; b_wd = 0;
      iss_valid = 0; iss_rd = 0; chk_r1 = 0; chk_r2 = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic do_reset();
      idle(); rst_n = 0; settle(); tick(); rst_n = 1;
   endtask

   task automatic reserve(input logic [4:0] rd);
      idle(); iss_valid = 1; iss_rd = rd; settle(); tick(); idle();
   endtask

   task automatic test_reset();
      idle(); a_we = 1; a_rd = 1; b_valid = 1; b_rd = 2; iss_valid = 1; iss_rd = 3;
      settle();
      nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL rst_rf_we got %0b exp 0", rf_we); end
      nvec++; if (b_ready !== 1'b0) begin nerr++; $display("FAIL rst_b_ready got %0b exp 0", b_ready); end
      nvec++; if (iss_ready !== 1'b0) begin nerr++; $display("FAIL rst_iss_ready got %0b exp 0", iss_ready); end
      nvec++; if ({a_freeze, err} !== 2'b00) begin nerr++; $display("FAIL rst_state got %b exp 00", {a_freeze, err}); end
      tick(); rst_n = 1; idle();
      // build up state: r5 pending, freeze set, err set
      reserve(5'd5);
      a_we = 1; a_rd = 3; b_valid = 1; b_rd = 5; b_wd = 32'h1;
      repeat (SL) tick();
      a_rd = 5; chk_r1 = 5; settle();
      nvec++; if (a_freeze !== 1'b1) begin nerr++; $display("FAIL mid_freeze got %0b exp 1", a_freeze); end
      nvec++; if (busy1 !== 1'b1) begin nerr++; $display("FAIL mid_busy5 got %0b exp 1", busy1); end
      tick();
      nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL mid_err got %0b exp 1", err); end
      rst_n = 0; settle();
      nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL midrst_rf_we got %0b exp 0", rf_we); end
      nvec++; if ({a_freeze, err, busy1} !== 3'b000) begin nerr++; $display("FAIL midrst_state got %b exp 000", {a_freeze, err, busy1}); end
      tick(); rst_n = 1; idle(); chk_r1 = 5; settle();
      nvec++; if ({a_freeze, err, busy1} !== 3'b000) begin nerr++; $display("FAIL postrst_state got %b exp 000", {a_freeze, err, busy1}); end
      tick();
   endtask

   task automatic test_priority();
      reserve(5'd7);
      a_we = 1; a_rd = 3; a_wd = 32'h11; b_valid = 1; b_rd = 7; b_wd = 32'h77; settle();
      nvec++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd3, 32'h11}) begin nerr++; $display("FAIL prio_a got we=%0b wr=%0d wd=%0h exp 1 3 11", rf_we, rf_wr, rf_wd); end
      nvec++; if (b_ready !== 1'b0) begin nerr++; $display("FAIL prio_b_ready got %0b exp 0", b_ready); end
      tick(); a_we = 0; settle();
      nvec++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd7, 32'h77}) begin nerr++; $display("FAIL prio_b got we=%0b wr=%0d wd=%0h exp 1 7 77", rf_we, rf_wr, rf_wd); end
      nvec++; if (b_ready !== 1'b1) begin nerr++; $display("FAIL prio_b_ready2 got %0b exp 1", b_ready); end
      tick(); idle(); settle();
      nvec++; if ({rf_we, rf_wr, rf_wd, err} !== {1'b0, 5'd0, 32'h0, 1'b0}) begin nerr++; $display("FAIL prio_idle got we=%0b wr=%0d wd=%0h err=%0b", rf_we, rf_wr, rf_wd, err); end
      tick();
   endtask

   task automatic test_starvation();
      reserve(5'd8);
      for (int i = 1; i <= SL; i++) begin
         a_we = 1; a_rd = 2; a_wd = i; b_valid = 1; b_rd = 8; b_wd = 32'h88; settle();
         nvec++; if ({b_ready, a_freeze} !== 2'b00) begin nerr++; $display("FAIL starve_c%0d got rdy/frz=%b exp 00", i, {b_ready, a_freeze}); end
         tick();
      end
      a_we = 0; settle();
      nvec++; if ({a_freeze, b_ready, rf_wr} !== {1'b1, 1'b1, 5'd8}) begin nerr++; $display("FAIL starve_c5 got frz=%0b rdy=%0b wr=%0d exp 1 1 8", a_freeze, b_ready, rf_wr); end
      tick(); idle(); settle();
      nvec++; if ({a_freeze, err} !== 2'b00) begin nerr++; $display("FAIL starve_c6 got frz/err=%b exp 00", {a_freeze, err}); end
      tick();
      // an idle B cycle must restart the count
      reserve(5'd8);
      a_we = 1; a_rd = 2; b_valid = 1; b_rd = 8; tick();
      b_valid = 0; tick();
      b_valid = 1; repeat (SL - 1) tick();
      settle();
      nvec++; if (a_freeze !== 1'b0) begin nerr++; $display("FAIL starve_clear got %0b exp 0", a_freeze); end
      a_we = 0; tick(); idle(); tick();
   endtask

   task automatic test_scoreboard();
      idle(); iss_valid = 1; iss_rd = 9; chk_r1 = 9; settle();
      nvec++; if ({iss_ready, busy1} !== 2'b10) begin nerr++; $display("FAIL sb_issue got rdy/busy=%b exp 10", {iss_ready, busy1}); end
      tick(); settle();
      nvec++; if ({iss_ready, busy1} !== 2'b01) begin nerr++; $display("FAIL sb_reissue got rdy/busy=%b exp 01", {iss_ready, busy1}); end
      tick(); b_valid = 1; b_rd = 9; b_wd = 32'h99; settle();
      nvec++; if ({b_ready, busy1, iss_ready} !== 3'b110) begin nerr++; $display("FAIL sb_commit got rdy/busy/iss=%b exp 110", {b_ready, busy1, iss_ready}); end
      tick(); b_valid = 0; settle();
      nvec++; if ({busy1, iss_ready} !== 2'b01) begin nerr++; $display("FAIL sb_after got busy/iss=%b exp 01", {busy1, iss_ready}); end
      tick(); iss_valid = 0; settle();
      nvec++; if ({busy1, err} !== 2'b10) begin nerr++; $display("FAIL sb_rebusy got busy/err=%b exp 10", {busy1, err}); end
      b_valid = 1; tick(); idle(); tick();
   endtask

   task automatic test_x0();
      idle(); iss_valid = 1; iss_rd = 0; chk_r2 = 0; settle();
      nvec++; if ({iss_ready, busy2} !== 2'b10) begin nerr++; $display("FAIL x0_issue got rdy/busy=%b exp 10", {iss_ready, busy2}); end
      tick(); iss_valid = 0; b_valid = 1; b_rd = 0; b_wd = 32'h5; settle();
      nvec++; if ({busy2, b_ready, rf_we, rf_wr} !== {1'b0, 1'b1, 1'b1, 5'd0}) begin nerr++; $display("FAIL x0_commit got busy=%0b rdy=%0b we=%0b wr=%0d", busy2, b_ready, rf_we, rf_wr); end
      tick(); idle(); settle();
      nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL x0_err got %0b exp 0", err); end
      tick();
   endtask

   task automatic test_violations();
      do_reset();
      b_valid = 1; b_rd = 12; b_wd = 32'hC; settle();
      nvec++; if ({rf_we, rf_wr} !== {1'b1, 5'd12}) begin nerr++; $display("FAIL viol_b_write got we=%0b wr=%0d exp 1 12", rf_we, rf_wr); end
      tick(); idle(); settle();
      nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL viol_b_err got %0b exp 1", err); end
      do_reset(); reserve(5'd4);
      a_we = 1; a_rd = 4; a_wd = 32'hABCD; chk_r2 = 4; settle();
      nvec++; if ({rf_we, rf_wr, rf_wd, err} !== {1'b1, 5'd4, 32'hABCD, 1'b0}) begin nerr++; $display("FAIL viol_waw_write got we=%0b wr=%0d wd=%0h err=%0b", rf_we, rf_wr, rf_wd, err); end
      tick(); a_we = 0; settle();
      nvec++; if ({err, busy2} !== 2'b11) begin nerr++; $display("FAIL viol_waw got err/busy=%b exp 11", {err, busy2}); end
      tick();
   endtask

   task automatic test_random();
      bit pend[32];
      int starve, r;
      bit frz, merr, hold, e_bready, e_iss, refused, commit;
      logic [4:0]  e_wr;
      logic [31:0] e_wd;
      do_reset();
      for (int i = 0; i < 32; i++) pend[i] = 0;
      starve = 0; frz = 0; merr = 0; hold = 0;
      for (int c = 0; c < 600; c++) begin
         if (!hold) begin
            b_valid = ($urandom_range(0, 2) != 0);
            r = $urandom_range(1, 31);
            if ($urandom_range(0, 4) != 0)
               for (int k = 0; k < 31; k++) begin
                  if (pend[r]) break;
                  r = (r % 31) + 1;
               end
            b_rd = 5'(r); b_wd = $urandom;
         end
         a_we = frz ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
         a_rd = 5'($urandom_range(0, 31));
         if (pend[a_rd] && $urandom_range(0, 3) != 0) a_rd = 0;
         a_wd = $urandom;
         iss_valid = $urandom_range(0, 1); iss_rd = 5'($urandom_range(0, 31));
         chk_r1 = 5'($urandom_range(0, 31)); chk_r2 = 5'($urandom_range(0, 31));

         e_bready = !a_we && b_valid;
         e_wr = a_we ? a_rd : (b_valid ? b_rd : 5'd0);
         e_wd = a_we ? a_wd : (b_valid ? b_wd : 32'd0);
         e_iss = iss_valid && (iss_rd == 0 || !pend[iss_rd]);
         settle();
         nvec++; if (rf_we !== (a_we | b_valid)) begin nerr++; $display("FAIL rnd_we c%0d got %0b exp %0b", c, rf_we, a_we | b_valid); end
         nvec++; if ({rf_wr, rf_wd} !== {e_wr, e_wd}) begin nerr++; $display("FAIL rnd_wport c%0d got %0d/%0h exp %0d/%0h", c, rf_wr, rf_wd, e_wr, e_wd); end
         nvec++; if (b_ready !== e_bready) begin nerr++; $display("FAIL rnd_b_ready c%0d got %0b exp %0b", c, b_ready, e_bready); end
         nvec++; if (iss_ready !== e_iss) begin nerr++; $display("FAIL rnd_iss_ready c%0d got %0b exp %0b", c, iss_ready, e_iss); end
         nvec++; if ({busy1, busy2} !== {pend[chk_r1], pend[chk_r2]}) begin nerr++; $display("FAIL rnd_busy c%0d got %b exp %b", c, {busy1, busy2}, {pend[chk_r1], pend[chk_r2]}); end
         nvec++; if ({a_freeze, err} !== {frz, merr}) begin nerr++; $display("FAIL rnd_frz_err c%0d got %b exp %b", c, {a_freeze, err}, {frz, merr}); end

         refused = b_valid && !e_bready;
         commit  = e_bready;
         if ((a_we && frz) || (a_we && pend[a_rd]) || (commit && b_rd != 0 && !pend[b_rd])) merr = 1;
         if (commit) frz = 0;
         else if (refused && starve == SL - 1) frz = 1;
         starve = refused ? ((starve < 15) ? starve + 1 : 15) : 0;
         if (commit) pend[b_rd] = 0;
         if (e_iss && iss_rd != 0) pend[iss_rd] = 1;
         pend[0] = 0;
         hold = refused;
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      #1;
      test_reset();
      test_priority();
      test_starvation();
      test_scoreboard();
      test_x0();
      test_violations();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
